// File: rtl/alu_entry_pkg.sv
// Shared definitions for the ALU operand entry front-end: state encoding,
// operand width and the sign-magnitude to two's-complement conversion.
package alu_entry_pkg;

  localparam int OPERAND_W = 4;
  localparam int MAG_W     = OPERAND_W - 1;
  localparam int OP_W      = 3;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  // Negative zero needs no special case: ~0000 + 1 wraps back to 0000.
  function automatic logic [OPERAND_W-1:0] sm_to_tc(input logic sign,
                                                     input logic [MAG_W-1:0] mag);
    logic [OPERAND_W-1:0] v;
    v = {1'b0, mag};
    if (sign) v = ~v + OPERAND_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/alu_operand_entry_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             level_prev;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], raw};
  end

  // Count consecutive disagreeing samples; the level flips on the Nth one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev <= 1'b0;
    else     level_prev <= level;
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand entry sequencer: collects A, B and opcode from the switches on
// successive "next" presses and presents a validated set to the ALU.
//
// state | meaning
// S_A   | waiting for operand A
// S_B   | waiting for operand B
// S_OP  | waiting for opcode
// S_RUN | a, b, op complete; alu_valid high
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_sign,
  input  logic [2:0] sw_mag,
  input  logic [2:0] sw_op,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic       alu_valid,
  output logic [1:0] stage
);

  logic             sign_s1, sign_s2;
  logic [MAG_W-1:0] mag_s1, mag_s2;
  logic [OP_W-1:0]  op_s1, op_s2;
  logic             next_press, clr_press;
  state_t           state, state_nxt;
  logic             load_a, load_b, load_op, clear_regs;
  logic [OPERAND_W-1:0] conv;

  // Two-flop synchronizers for the switch bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_s1 <= 1'b0;
      sign_s2 <= 1'b0;
      mag_s1  <= '0;
      mag_s2  <= '0;
      op_s1   <= '0;
      op_s2   <= '0;
    end else begin
      sign_s1 <= sw_sign;
      sign_s2 <= sign_s1;
      mag_s1  <= sw_mag;
      mag_s2  <= mag_s1;
      op_s1   <= sw_op;
      op_s2   <= op_s1;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .press (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clr),
    .press (clr_press)
  );

  assign conv = sm_to_tc(sign_s2, mag_s2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= state_nxt;
  end

  // Next-state and load strobes; a clear press overrides a coincident next.
  always_comb begin
    state_nxt  = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    clear_regs = 1'b0;
    if (clr_press) begin
      clear_regs = 1'b1;
      state_nxt  = S_A;
    end else if (next_press) begin
      case (state)
        S_A: begin
          load_a    = 1'b1;
          state_nxt = S_B;
        end
        S_B: begin
          load_b    = 1'b1;
          state_nxt = S_OP;
        end
        S_OP: begin
          load_op   = 1'b1;
          state_nxt = S_RUN;
        end
        default: state_nxt = S_A;
      endcase
    end
  end

  // Operand registers only move on press cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a  <= '0;
      b  <= '0;
      op <= '0;
    end else if (clear_regs) begin
      a  <= '0;
      b  <= '0;
      op <= '0;
    end else begin
      if (load_a)  a  <= conv;
      if (load_b)  b  <= conv;
      if (load_op) op <= op_s2;
    end
  end

  assign alu_valid = (state == S_RUN);
  assign stage     = state;

endmodule
